// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path.
// Contents:
//   state_e      - main control FSM state encoding
//   OP_*         - major opcodes (IR[6:0]) recognised by the decoder
//   ALU_OP_*     - 2-bit ALUOp codes consumed by ALUControl
//   SRC_A_*/SRC_B_*/RES_* - datapath mux select codes
//   ctrl_t       - Moore control word decoded from the FSM state
//   decode_ctrl  - state -> control word lookup
package core_ctrl_pkg;

   typedef enum logic [3:0] {
      StFetch,
      StDecode,
      StMemAdr,
      StMemRd,
      StMemWb,
      StMemWr,
      StExecR,
      StExecI,
      StAluWb,
      StBeq,
      StJal,
      StHalt
   } state_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   localparam logic [1:0] SRC_A_PC     = 2'b00;
   localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
   localparam logic [1:0] SRC_A_RS1    = 2'b10;

   localparam logic [1:0] SRC_B_RS2  = 2'b00;
   localparam logic [1:0] SRC_B_IMM  = 2'b01;
   localparam logic [1:0] SRC_B_FOUR = 2'b10;

   localparam logic [1:0] RES_ALU_OUT    = 2'b00;
   localparam logic [1:0] RES_MEM_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU_RESULT = 2'b10;

   typedef struct packed {
      logic       mem_req;
      logic       mem_write;
      logic       adr_src;
      logic       fetch;       // IR/PC update, qualified by mem_ready
      logic       pc_update;   // unconditional PC write (JAL)
      logic       branch;      // PC write qualified by zero
      logic       reg_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       funct7b5_en;
      logic       halted;
   } ctrl_t;

   function automatic ctrl_t decode_ctrl(input state_e st);
      ctrl_t c;
      c = '0;
      case (st)
         StFetch: begin
            c.mem_req    = 1'b1;
            c.fetch      = 1'b1;
            c.alu_src_a  = SRC_A_PC;
            c.alu_src_b  = SRC_B_FOUR;
            c.alu_op     = ALU_OP_ADD;
            c.result_src = RES_ALU_RESULT;
         end
         StDecode: begin
            // Branch target PC+imm lands in ALUOut for a later BEQ
            c.alu_src_a = SRC_A_OLD_PC;
            c.alu_src_b = SRC_B_IMM;
            c.alu_op    = ALU_OP_ADD;
         end
         StMemAdr: begin
            c.alu_src_a = SRC_A_RS1;
            c.alu_src_b = SRC_B_IMM;
            c.alu_op    = ALU_OP_ADD;
         end
         StMemRd: begin
            c.mem_req = 1'b1;
            c.adr_src = 1'b1;
         end
         StMemWb: begin
            c.result_src = RES_MEM_DATA;
            c.reg_write  = 1'b1;
         end
         StMemWr: begin
            c.mem_req   = 1'b1;
            c.mem_write = 1'b1;
            c.adr_src   = 1'b1;
         end
         StExecR: begin
            c.alu_src_a   = SRC_A_RS1;
            c.alu_src_b   = SRC_B_RS2;
            c.alu_op      = ALU_OP_FUNCT;
            c.funct7b5_en = 1'b1;
         end
         StExecI: begin
            // funct7b5 masked so ADDI with imm[10]=1 is not seen as SUB
            c.alu_src_a = SRC_A_RS1;
            c.alu_src_b = SRC_B_IMM;
            c.alu_op    = ALU_OP_FUNCT;
         end
         StAluWb: begin
            c.result_src = RES_ALU_OUT;
            c.reg_write  = 1'b1;
         end
         StBeq: begin
            c.alu_src_a  = SRC_A_RS1;
            c.alu_src_b  = SRC_B_RS2;
            c.alu_op     = ALU_OP_SUB;
            c.result_src = RES_ALU_OUT;
            c.branch     = 1'b1;
         end
         StJal: begin
            c.alu_src_a  = SRC_A_OLD_PC;
            c.alu_src_b  = SRC_B_FOUR;
            c.alu_op     = ALU_OP_ADD;
            c.result_src = RES_ALU_OUT;
            c.pc_update  = 1'b1;
         end
         StHalt: begin
            c.halted = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Unified memory port handshake between the control FSM and memory.
// Signals:
//   mem_req   - access request, held until mem_ready
//   mem_write - store qualifier for mem_req
//   adr_src   - address select: 0 = PC, 1 = ALUOut
//   mem_ready - memory completes the current access this cycle
// Modports: master (controller side), slave (memory side).
interface multicycle_control_if;
   logic mem_req;
   logic mem_write;
   logic adr_src;
   logic mem_ready;

   modport master (output mem_req, output mem_write, output adr_src, input mem_ready);
   modport slave  (input mem_req, input mem_write, input adr_src, output mem_ready);
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I core.
// Ports:
//   clk, rst_n      - clock (rising edge), asynchronous active-low reset
//   op_i            - opcode IR[6:0]
//   zero_i          - ALU zero flag (BEQ)
//   mem             - memory handshake (master modport)
//   ir_write_o      - load IR and OldPC
//   pc_write_o      - PC enable: pc_update | (branch & zero)
//   reg_write_o     - register file write enable
//   result_src_o    - result mux select
//   alu_src_a_o/b_o - ALU operand selects
//   alu_op_o        - ALUOp to ALUControl
//   funct7b5_en_o   - gate for Funct7b5 into ALUControl
//   halted_o        - sticky illegal-opcode indication
//   instret_o       - retired instruction count (wraps)
module multicycle_control
   import core_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W        = 32,
   parameter bit          ILLEGAL_HALT = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [6:0]            op_i,
   input  logic                  zero_i,
   multicycle_control_if.master  mem,
   output logic                  ir_write_o,
   output logic                  pc_write_o,
   output logic                  reg_write_o,
   output logic [1:0]            result_src_o,
   output logic [1:0]            alu_src_a_o,
   output logic [1:0]            alu_src_b_o,
   output logic [1:0]            alu_op_o,
   output logic                  funct7b5_en_o,
   output logic                  halted_o,
   output logic [CNT_W-1:0]      instret_o
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   instret_q, instret_d;
   ctrl_t              ctrl;

   always_comb begin
      state_d = state_q;
      case (state_q)
         StFetch:  if (mem.mem_ready) state_d = StDecode;
         StDecode: begin
            case (op_i)
               OP_LOAD, OP_STORE: state_d = StMemAdr;
               OP_RTYPE:          state_d = StExecR;
               OP_ITYPE:          state_d = StExecI;
               OP_BRANCH:         state_d = StBeq;
               OP_JAL:            state_d = StJal;
               default:           state_d = ILLEGAL_HALT ? StHalt : StFetch;
            endcase
         end
         StMemAdr: state_d = (op_i == OP_LOAD) ? StMemRd : StMemWr;
         StMemRd:  if (mem.mem_ready) state_d = StMemWb;
         StMemWb:  state_d = StFetch;
         StMemWr:  if (mem.mem_ready) state_d = StFetch;
         StExecR:  state_d = StAluWb;
         StExecI:  state_d = StAluWb;
         StAluWb:  state_d = StFetch;
         StBeq:    state_d = StFetch;
         StJal:    state_d = StAluWb;
         StHalt:   state_d = StHalt;
         default:  state_d = StFetch;
      endcase
   end

   // Every entry into FETCH from another state retires one instruction
   always_comb begin
      instret_d = instret_q;
      if ((state_q != StFetch) && (state_d == StFetch)) begin
         instret_d = instret_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StFetch;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
      end
   end

   // While reset is held the control word is forced inactive, so a pending
   // access is dropped at once even though the reset state is FETCH.
   always_comb begin
      ctrl = '0;
      if (rst_n) begin
         ctrl = decode_ctrl(state_q);
      end
   end

   assign mem.mem_req   = ctrl.mem_req;
   assign mem.mem_write = ctrl.mem_write;
   assign mem.adr_src   = ctrl.adr_src;

   assign ir_write_o    = ctrl.fetch & mem.mem_ready;
   assign pc_write_o    = (ctrl.fetch & mem.mem_ready) | ctrl.pc_update |
                          (ctrl.branch & zero_i);
   assign reg_write_o   = ctrl.reg_write;
   assign result_src_o  = ctrl.result_src;
   assign alu_src_a_o   = ctrl.alu_src_a;
   assign alu_src_b_o   = ctrl.alu_src_b;
   assign alu_op_o      = ctrl.alu_op;
   assign funct7b5_en_o = ctrl.funct7b5_en;
   assign halted_o      = ctrl.halted;
   assign instret_o     = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the stimulus process pushes the
// hand-computed expected output word for each driven cycle, and a monitor
// pops and compares at the falling edge (or on demand for async reset).
module tb_multicycle_control;

   typedef struct packed {
      logic        req;
      logic        wr;
      logic        adr;
      logic        irw;
      logic        pcw;
      logic        rw;
      logic [1:0]  res;
      logic [1:0]  a;
      logic [1:0]  b;
      logic [1:0]  aop;
      logic        f7;
      logic        h;
      logic [31:0] cnt;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [6:0]  op_i = '0;
   logic        zero_i = 1'b0;
   logic        ir_write, pc_write, reg_write, funct7b5_en, halted;
   logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op;
   logic [31:0] instret;

   int checks = 0;
   int errors = 0;

   obs_t  exp_q[$];
   string name_q[$];
   event  sample_ev;
   obs_t  act;

   multicycle_control_if mif ();

   multicycle_control #(
      .CNT_W        (32),
      .ILLEGAL_HALT (1'b1)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .op_i          (op_i),
      .zero_i        (zero_i),
      .mem           (mif.master),
      .ir_write_o    (ir_write),
      .pc_write_o    (pc_write),
      .reg_write_o   (reg_write),
      .result_src_o  (result_src),
      .alu_src_a_o   (alu_src_a),
      .alu_src_b_o   (alu_src_b),
      .alu_op_o      (alu_op),
      .funct7b5_en_o (funct7b5_en),
      .halted_o      (halted),
      .instret_o     (instret)
   );

   always #5 clk = ~clk;

   assign act = {mif.mem_req, mif.mem_write, mif.adr_src, ir_write, pc_write, reg_write,
                 result_src, alu_src_a, alu_src_b, alu_op, funct7b5_en, halted, instret};

   function automatic obs_t e(input logic req, input logic wr, input logic adr,
                              input logic irw, input logic pcw, input logic rw,
                              input logic [1:0] res, input logic [1:0] a,
                              input logic [1:0] b, input logic [1:0] aop,
                              input logic f7, input logic h, input logic [31:0] cnt);
      return '{req, wr, adr, irw, pcw, rw, res, a, b, aop, f7, h, cnt};
   endfunction

   function automatic obs_t fetch(input logic rdy, input logic [31:0] cnt);
      return e(1, 0, 0, rdy, rdy, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, cnt);
   endfunction

   function automatic obs_t decode(input logic [31:0] cnt);
      return e(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0, cnt);
   endfunction

   function automatic obs_t aluwb(input logic [31:0] cnt);
      return e(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, cnt);
   endfunction

   function automatic obs_t memadr(input logic [31:0] cnt);
      return e(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0, cnt);
   endfunction

   // Monitor: one comparison per queued expectation
   initial begin
      forever begin
         @(negedge clk or sample_ev);
         if (exp_q.size() > 0) begin
            obs_t  ex;
            string nm;
            ex = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (act !== ex) begin
               errors++;
               $display("FAIL %s: got %h want %h (t=%0t)", nm, act, ex, $time);
            end
         end
      end
   end

   // Drive one cycle of inputs and queue its expected outputs
   task automatic cyc(input string nm, input logic [6:0] op, input logic z,
                      input logic rdy, input obs_t ex);
      op_i          = op;
      zero_i        = z;
      mif.mem_ready = rdy;
      exp_q.push_back(ex);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   // Immediate (off-edge) check, used while reset is asserted
   task automatic now_chk(input string nm, input obs_t ex);
      exp_q.push_back(ex);
      name_q.push_back(nm);
      -> sample_ev;
      #1;
   endtask

   localparam logic [6:0] R   = 7'b0110011;
   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] BEQ = 7'b1100011;
   localparam logic [6:0] ADI = 7'b0010011;
   localparam logic [6:0] JAL = 7'b1101111;
   localparam logic [6:0] BAD = 7'b1111111;

   initial begin
      mif.mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      now_chk("reset_state", e(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0));
      rst_n = 1'b1;

      // R-type, zero wait states: 4 cycles
      cyc("r_fetch",  R, 0, 1, fetch(1, 0));
      cyc("r_decode", R, 0, 1, decode(0));
      cyc("r_execr",  R, 0, 1, e(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 1, 0, 0));
      cyc("r_aluwb",  R, 0, 1, aluwb(0));

      // lw with 3 wait cycles in MEMRD: 8 cycles
      cyc("lw_fetch",  LW, 0, 1, fetch(1, 1));
      cyc("lw_decode", LW, 0, 1, decode(1));
      cyc("lw_memadr", LW, 0, 1, memadr(1));
      for (int i = 0; i < 3; i++) begin
         cyc("lw_memrd_wait", LW, 0, 0, e(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1));
      end
      cyc("lw_memrd_done", LW, 0, 1, e(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1));
      cyc("lw_memwb",      LW, 0, 1, e(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 1));

      // beq taken, with one fetch wait cycle first
      cyc("beq_fetch_wait", BEQ, 1, 0, fetch(0, 2));
      cyc("beq_fetch",      BEQ, 1, 1, fetch(1, 2));
      cyc("beq_decode",     BEQ, 1, 1, decode(2));
      cyc("beq_taken",      BEQ, 1, 1, e(0, 0, 0, 0, 1, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0, 2));
      // beq not taken
      cyc("beqn_fetch",     BEQ, 0, 1, fetch(1, 3));
      cyc("beqn_decode",    BEQ, 0, 1, decode(3));
      cyc("beq_not_taken",  BEQ, 0, 1, e(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0, 3));

      // addi then jal
      cyc("i_fetch",   ADI, 0, 1, fetch(1, 4));
      cyc("i_decode",  ADI, 0, 1, decode(4));
      cyc("i_execi",   ADI, 1, 1, e(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 0, 4));
      cyc("i_aluwb",   ADI, 0, 1, aluwb(4));
      cyc("jal_fetch", JAL, 0, 1, fetch(1, 5));
      cyc("jal_decode", JAL, 0, 1, decode(5));
      cyc("jal_jal",   JAL, 0, 1, e(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 5));
      cyc("jal_aluwb", JAL, 0, 1, aluwb(5));

      // Illegal opcode: sticky HALT, mem_ready ignored
      cyc("bad_fetch",  BAD, 0, 1, fetch(1, 6));
      cyc("bad_decode", BAD, 0, 1, decode(6));
      for (int i = 0; i < 10; i++) begin
         cyc("halt", BAD, 0, 1, e(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 6));
      end
      rst_n = 1'b0;
      #1;
      now_chk("halt_reset", e(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0));
      rst_n = 1'b1;

      // sw zero wait, then sw interrupted by reset while waiting
      cyc("sw_fetch",  SW, 0, 1, fetch(1, 0));
      cyc("sw_decode", SW, 0, 1, decode(0));
      cyc("sw_memadr", SW, 0, 1, memadr(0));
      cyc("sw_memwr",  SW, 0, 1, e(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0));
      cyc("sw2_fetch", SW, 0, 1, fetch(1, 1));
      cyc("sw2_decode", SW, 0, 1, decode(1));
      cyc("sw2_memadr", SW, 0, 0, memadr(1));
      cyc("sw2_memwr_wait", SW, 0, 0, e(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1));
      rst_n = 1'b0;
      #1;
      now_chk("sw_abort", e(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0));
      rst_n = 1'b1;
      cyc("post_reset_fetch", R, 0, 0, fetch(0, 0));
      cyc("post_reset_fetch2", R, 0, 1, fetch(1, 0));

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Sequences the shared ALU, PC, IR and unified memory port over FETCH/DECODE/EXECUTE/MEM/WB steps.
- Drives the 2-bit ALUOp consumed by ALUControl, plus all datapath mux selects and write enables.
- Handshakes with memory via mem_req/mem_ready and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter instret.
- ILLEGAL_HALT, 1, 1 = unknown opcode enters sticky HALT; 0 = treat as NOP and return to FETCH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  7  instruction opcode from IR[6:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request; held until mem_ready.
- mem_write  out  1  store qualifier for mem_req.
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR (and OldPC).
- pc_write  out  1  PC register enable.
- reg_write  out  1  register file write enable.
- result_src  out  2  00 = ALUOut, 01 = MemData, 10 = ALU result.
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1.
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- alu_op  out  2  to ALUControl: 00 = add, 01 = sub (branch), 10 = funct-decoded.
- funct7b5_en  out  1  datapath ANDs Funct7b5 with this before ALUControl.
- halted  out  1  sticky illegal-opcode indication.
- instret  out  CNT_W  retired instruction count.

Behaviour:
- Async reset (rst_n=0), state is FETCH:
  - all enables 0, mem_req 0, selects 00, halted 0, instret 0.
  - Reset asserted mid-access drops mem_req immediately; the pending access is abandoned.
- Outputs are Moore-decoded from state, except ir_write/pc_write in FETCH, which are qualified by mem_ready.
- pc_write = pc_update | (branch & zero).
- States and transitions (unlisted outputs inactive/00):
  - FETCH:
    - Outputs: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
    - When mem_ready: ir_write=1, pc_update=1, go to DECODE; else stay in FETCH.
  - DECODE:
    - Outputs: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut).
    - op 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL.
    - Any other op -> HALT if ILLEGAL_HALT, else FETCH (counted as retired).
  - MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next is MEMRD if op=0000011, else MEMWR.
  - MEMRD: mem_req=1, adr_src=1. Wait for mem_ready, then MEMWB.
  - MEMWB: result_src=01, reg_write=1. Next FETCH.
  - MEMWR: mem_req=1, mem_write=1, adr_src=1. Wait for mem_ready, then FETCH.
  - EXECR: alu_src_a=10, alu_src_b=00, alu_op=10, funct7b5_en=1. Next ALUWB.
  - EXECI: alu_src_a=10, alu_src_b=01, alu_op=10, funct7b5_en=0, so ADDI with imm[10]=1 still adds. Next ALUWB.
  - ALUWB: result_src=00, reg_write=1. Next FETCH.
  - BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1. Next FETCH.
  - JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1. Next ALUWB (rd = OldPC+4).
  - HALT: halted=1, everything else inactive. Exit only by reset.
- Memory handshake:
  - mem_req, mem_write and adr_src stay stable while waiting.
  - mem_ready outside MEMRD/MEMWR/FETCH is ignored.
  - mem_ready in the same cycle as the request completes it (zero wait states).
- instret:
  - +1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, BEQ, or DECODE (illegal NOP case).
  - Wraps modulo 2^CNT_W.
- Latency with zero wait states:
  - lw 5 cycles; sw, R, I, jal 4 cycles; beq 3 cycles.
  - Each memory wait cycle adds 1.

Decomposition:
- Shared package core_ctrl_pkg holds:
  - state encoding constants;
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL);
  - ALUOp codes 00/01/10;
  - alu_src_a, alu_src_b and result_src select codes.
- No sub-module: next-state logic, output decode and the instret counter live in one block. ALUControl is instantiated alongside it in the core top.

Test Plan:
- Reset then op=0110011, mem_ready=1 always: states FETCH->DECODE->EXECR->ALUWB. EXECR shows alu_op=10, funct7b5_en=1; ALUWB shows reg_write=1; instret=1 after 4 cycles.
- op=0000011 with mem_ready low for 3 cycles in MEMRD: mem_req=1 and adr_src=1 held for 4 cycles, then MEMWB with result_src=01, reg_write=1. Total 8 cycles.
- op=1100011: with zero=1, BEQ cycle gives pc_write=1 and alu_op=01; with zero=0, pc_write=0. Both return to FETCH, and instret increments each time.
- op=0010011: EXECI shows funct7b5_en=0 and alu_src_b=01. Then op=1101111: JAL gives pc_write=1, then ALUWB with reg_write=1.
- op=1111111 with ILLEGAL_HALT=1: HALT, halted=1, and mem_req stays 0 for 10 cycles. Pulsing rst_n low returns to FETCH with halted=0 and instret=0.
- rst_n asserted in MEMWR while mem_req=1: mem_req and mem_write drop to 0 without waiting for a clock. After release, the first cycle is FETCH with mem_req=1 and adr_src=0.
